// File: rtl/rob_commit.sv
// In-order reorder buffer with single-wide retire, writeback completion tracking
// and mispredict squash of everything younger than the resolved branch.
module rob_commit #(
  parameter int DEPTH  = 16,
  parameter int PREG_W = 6,
  parameter int AREG_W = 5,
  parameter int TAG_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              alloc_valid_i,
  output logic              alloc_ready_o,
  input  logic              alloc_rd_valid_i,
  input  logic [AREG_W-1:0] alloc_rd_arch_i,
  input  logic [PREG_W-1:0] alloc_rd_phys_i,
  input  logic [PREG_W-1:0] alloc_old_phys_i,
  output logic [TAG_W-1:0]  alloc_tag_o,
  input  logic              wb_valid_i,
  input  logic [TAG_W-1:0]  wb_tag_i,
  input  logic              br_valid_i,
  input  logic              br_hit_i,
  input  logic [TAG_W-1:0]  br_tag_i,
  output logic [PREG_W:0]   p_commit_o,
  output logic              free_valid_o,
  output logic [PREG_W-1:0] free_idx_o,
  output logic              empty_o,
  output logic [TAG_W:0]    count_o
);

  localparam int PTR_W = TAG_W + 1;

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  done_q, done_d;
  logic [DEPTH-1:0]  rd_valid_q;
  logic [PREG_W-1:0] rd_phys_q  [DEPTH];
  logic [PREG_W-1:0] old_phys_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;

  logic [PREG_W:0]   p_commit_q;
  logic              free_valid_q;
  logic [PREG_W-1:0] free_idx_q;

  logic [TAG_W-1:0]  head_idx, tail_idx, br_dist;
  logic [PTR_W-1:0]  count, br_ptr;
  logic              mispredict, retire, alloc_fire;

  // Distance of an entry from the head, in program order.
  function automatic logic [TAG_W-1:0] age_of(input logic [TAG_W-1:0] idx,
                                              input logic [TAG_W-1:0] hd);
    return idx - hd;
  endfunction

  assign head_idx   = head_q[TAG_W-1:0];
  assign tail_idx   = tail_q[TAG_W-1:0];
  assign count      = tail_q - head_q;
  assign mispredict = br_valid_i && !br_hit_i && valid_q[br_tag_i];
  assign retire     = valid_q[head_idx] && done_q[head_idx];
  assign alloc_fire = alloc_valid_i && alloc_ready_o && !mispredict;

  // The branch pointer is rebuilt from the head so the wrap bit stays consistent.
  assign br_dist = age_of(br_tag_i, head_idx);
  assign br_ptr  = head_q + PTR_W'(br_dist);

  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (wb_valid_i && valid_q[wb_tag_i]) begin
      done_d[wb_tag_i] = 1'b1;
    end
    if (retire) begin
      valid_d[head_idx] = 1'b0;
      head_d            = head_q + PTR_W'(1);
    end
    if (mispredict) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (age_of(TAG_W'(i), head_idx) > br_dist) begin
          valid_d[i] = 1'b0;
          done_d[i]  = 1'b0;
        end
      end
      tail_d = br_ptr + PTR_W'(1);
    end else if (alloc_fire) begin
      valid_d[tail_idx] = 1'b1;
      done_d[tail_idx]  = 1'b0;
      tail_d            = tail_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Payload storage carries no reset; it is only read behind a valid bit.
  always_ff @(posedge clk_i) begin
    if (alloc_fire) begin
      rd_valid_q[tail_idx] <= alloc_rd_valid_i && (alloc_rd_arch_i != '0);
      rd_phys_q[tail_idx]  <= alloc_rd_phys_i;
      old_phys_q[tail_idx] <= alloc_old_phys_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p_commit_q   <= '0;
      free_valid_q <= 1'b0;
      free_idx_q   <= '0;
    end else if (retire) begin
      p_commit_q   <= rd_valid_q[head_idx] ? {1'b1, rd_phys_q[head_idx]} : '0;
      free_valid_q <= rd_valid_q[head_idx];
      free_idx_q   <= old_phys_q[head_idx];
    end else begin
      p_commit_q   <= '0;
      free_valid_q <= 1'b0;
      free_idx_q   <= '0;
    end
  end

  assign alloc_ready_o = (count != PTR_W'(DEPTH));
  assign alloc_tag_o   = tail_idx;
  assign count_o       = count;
  assign empty_o       = (count == '0);
  assign p_commit_o    = p_commit_q;
  assign free_valid_o  = free_valid_q;
  assign free_idx_o    = free_idx_q;

endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: directed scenarios with literal expectations, then random
// traffic compared every cycle against a queue-based program-order model.
module tb_rob_commit;

  localparam int DEPTH  = 16;
  localparam int PREG_W = 6;
  localparam int AREG_W = 5;
  localparam int TAG_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              alloc_valid, alloc_ready, alloc_rd_valid;
  logic [AREG_W-1:0] alloc_rd_arch;
  logic [PREG_W-1:0] alloc_rd_phys, alloc_old_phys;
  logic [TAG_W-1:0]  alloc_tag;
  logic              wb_valid;
  logic [TAG_W-1:0]  wb_tag;
  logic              br_valid, br_hit;
  logic [TAG_W-1:0]  br_tag;
  logic [PREG_W:0]   p_commit;
  logic              free_valid;
  logic [PREG_W-1:0] free_idx;
  logic              empty;
  logic [TAG_W:0]    count;

  rob_commit #(.DEPTH(DEPTH), .PREG_W(PREG_W), .AREG_W(AREG_W), .TAG_W(TAG_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready),
    .alloc_rd_valid_i(alloc_rd_valid), .alloc_rd_arch_i(alloc_rd_arch),
    .alloc_rd_phys_i(alloc_rd_phys), .alloc_old_phys_i(alloc_old_phys),
    .alloc_tag_o(alloc_tag),
    .wb_valid_i(wb_valid), .wb_tag_i(wb_tag),
    .br_valid_i(br_valid), .br_hit_i(br_hit), .br_tag_i(br_tag),
    .p_commit_o(p_commit), .free_valid_o(free_valid), .free_idx_o(free_idx),
    .empty_o(empty), .count_o(count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Program-order model: queue front is the oldest in-flight instruction.
  typedef struct packed {
    logic              rdv;
    logic [PREG_W-1:0] phys;
    logic [PREG_W-1:0] old;
    logic              done;
  } ent_t;

  ent_t              mq[$];
  int                head_cnt = 0;
  logic [PREG_W:0]   e_pc = '0;
  logic              e_fv = 1'b0;
  logic [PREG_W-1:0] e_fi = '0;

  function automatic int offs(input logic [TAG_W-1:0] tag);
    return (int'(tag) - (head_cnt % DEPTH) + DEPTH) % DEPTH;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Applies the inputs the DUT sampled at the last edge to the model.
  task automatic model_step();
    int   sz, kb, kw;
    bit   mis, ret;
    ent_t e;
    if (rst) begin
      mq.delete();
      head_cnt = 0;
      e_pc = '0; e_fv = 1'b0; e_fi = '0;
      return;
    end
    sz  = mq.size();
    kb  = offs(br_tag);
    mis = br_valid && !br_hit && (kb < sz);
    ret = (sz > 0) && mq[0].done;
    if (ret) begin
      e_pc = mq[0].rdv ? {1'b1, mq[0].phys} : '0;
      e_fv = mq[0].rdv;
      e_fi = mq[0].old;
    end else begin
      e_pc = '0; e_fv = 1'b0; e_fi = '0;
    end
    if (wb_valid) begin
      kw = offs(wb_tag);
      if (kw < sz && !(mis && kw > kb)) begin
        e = mq[kw]; e.done = 1'b1; mq[kw] = e;
      end
    end
    if (mis) begin
      while (mq.size() > kb + 1) void'(mq.pop_back());
    end
    if (ret) begin
      void'(mq.pop_front());
      head_cnt++;
    end
    if (!mis && alloc_valid && sz != DEPTH) begin
      e.rdv  = alloc_rd_valid && (alloc_rd_arch != 0);
      e.phys = alloc_rd_phys;
      e.old  = alloc_old_phys;
      e.done = 1'b0;
      mq.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", 32'(count), 32'(mq.size()));
      chk("empty", 32'(empty), 32'(mq.size() == 0));
      chk("ready", 32'(alloc_ready), 32'(mq.size() != DEPTH));
      chk("tag", 32'(alloc_tag), 32'((head_cnt + mq.size()) % DEPTH));
      chk("p_commit", 32'(p_commit), 32'(e_pc));
      chk("free_valid", 32'(free_valid), 32'(e_fv));
      if (e_fv) chk("free_idx", 32'(free_idx), 32'(e_fi));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic idle();
    alloc_valid = 1'b0; alloc_rd_valid = 1'b0; alloc_rd_arch = '0;
    alloc_rd_phys = '0; alloc_old_phys = '0;
    wb_valid = 1'b0; wb_tag = '0;
    br_valid = 1'b0; br_hit = 1'b0; br_tag = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic set_alloc(input logic rdv, input int arch, input int phys, input int old);
    alloc_valid    = 1'b1;
    alloc_rd_valid = rdv;
    alloc_rd_arch  = AREG_W'(arch);
    alloc_rd_phys  = PREG_W'(phys);
    alloc_old_phys = PREG_W'(old);
  endtask

  task automatic set_wb(input int tag);
    wb_valid = 1'b1;
    wb_tag   = TAG_W'(tag);
  endtask

  initial begin
    idle();
    rst = 1'b1;

    // Reset state
    do_reset();
    chk("rst_ready", 32'(alloc_ready), 32'd1);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_pcv", 32'(p_commit[PREG_W]), 32'd0);
    chk("rst_tag", 32'(alloc_tag), 32'd0);

    // Out-of-order completion, in-order retire
    set_alloc(1'b1, 5, 40, 5); tick();
    set_alloc(1'b1, 6, 41, 6); tick();
    idle(); set_wb(1); tick();
    idle(); set_wb(0); tick();
    idle(); tick();
    chk("ooo_commitA", 32'(p_commit), 32'h68);
    chk("ooo_freeA", 32'({free_valid, free_idx}), 32'h45);
    tick();
    chk("ooo_commitB", 32'(p_commit), 32'h69);
    chk("ooo_freeB", 32'({free_valid, free_idx}), 32'h46);
    tick();
    chk("ooo_empty", 32'(empty), 32'd1);

    // Full and wrap-around
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      chk("full_tag", 32'(alloc_tag), 32'(i));
      set_alloc(1'b1, 1 + i, i, 32 + i); tick();
    end
    chk("full_count", 32'(count), 32'd16);
    chk("full_ready", 32'(alloc_ready), 32'd0);
    set_alloc(1'b1, 9, 9, 9); tick();
    chk("full_count_hold", 32'(count), 32'd16);
    idle(); set_wb(0); tick();
    idle(); set_wb(1); tick();
    idle(); set_wb(2); tick();
    idle(); tick();
    chk("wrap_count", 32'(count), 32'd13);
    for (int i = 0; i < 3; i++) begin
      chk("wrap_tag", 32'(alloc_tag), 32'(i));
      set_alloc(1'b1, 3, 50 + i, 10 + i); tick();
    end
    idle();
    chk("wrap_count_full", 32'(count), 32'd16);

    // x0 destination and no-destination instructions
    do_reset();
    set_alloc(1'b1, 0, 7, 8); tick();
    set_alloc(1'b0, 3, 9, 10); tick();
    idle(); set_wb(0); tick();
    idle(); set_wb(1); tick();
    chk("x0_pc", 32'(p_commit), 32'd0);
    chk("x0_fv", 32'(free_valid), 32'd0);
    chk("x0_count", 32'(count), 32'd1);
    idle(); tick();
    chk("nord_pc", 32'(p_commit), 32'd0);
    chk("nord_fv", 32'(free_valid), 32'd0);
    chk("nord_count", 32'(count), 32'd0);

    // Mispredict at tag 2 with tags 0..5 in flight
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_alloc(1'b1, i + 1, 20 + i, 1 + i); tick();
    end
    idle(); br_valid = 1'b1; br_hit = 1'b0; br_tag = 4'd2; tick();
    chk("mis_count", 32'(count), 32'd3);
    chk("mis_tag", 32'(alloc_tag), 32'd3);
    idle(); set_wb(4); tick();
    chk("mis_wb_ignored", 32'(count), 32'd3);
    idle(); set_wb(0); tick();
    idle(); set_wb(1); tick();
    chk("mis_ret0", 32'(p_commit), 32'h54);
    idle(); set_wb(2); tick();
    chk("mis_ret1", 32'(p_commit), 32'h55);
    idle(); tick();
    chk("mis_ret2", 32'(p_commit), 32'h56);
    chk("mis_empty", 32'(empty), 32'd1);

    // Mispredict on a done head, together with an allocation
    do_reset();
    set_alloc(1'b1, 4, 50, 4); tick();
    set_alloc(1'b1, 7, 51, 7); tick();
    idle(); set_wb(0); tick();
    idle(); set_alloc(1'b1, 8, 52, 8);
    br_valid = 1'b1; br_hit = 1'b0; br_tag = 4'd0; tick();
    idle();
    chk("sim_pc", 32'(p_commit), 32'h72);
    chk("sim_empty", 32'(empty), 32'd1);
    chk("sim_count", 32'(count), 32'd0);
    chk("sim_tag", 32'(alloc_tag), 32'd1);
    tick();

    // Random traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      int sz, pa;
      idle();
      pa = (c < 2000) ? 75 : 40;
      sz = mq.size();
      rst = ($urandom_range(299) == 0);
      if ($urandom_range(99) < pa)
        set_alloc($urandom_range(9) != 0, $urandom_range(31),
                  $urandom_range(63), $urandom_range(63));
      if ($urandom_range(99) < 50) begin
        wb_valid = 1'b1;
        if (sz > 0 && $urandom_range(9) < 8)
          wb_tag = TAG_W'((head_cnt + $urandom_range(sz - 1)) % DEPTH);
        else
          wb_tag = TAG_W'($urandom_range(DEPTH - 1));
      end
      if ($urandom_range(99) < 5) begin
        br_valid = 1'b1;
        br_hit   = $urandom_range(1);
        if (sz > 0 && $urandom_range(9) < 8)
          br_tag = TAG_W'((head_cnt + $urandom_range(sz - 1)) % DEPTH);
        else
          br_tag = TAG_W'($urandom_range(DEPTH - 1));
      end
      tick();
    end
    rst = 1'b0;
    idle();
    tick();
    @(negedge clk);
    #1;
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rob_commit.md
# rob_commit

In-order reorder buffer and retire unit on the commit side of the rename stage. It records every renamed instruction in program order and marks entries complete on writeback. It retires one instruction per cycle, driving the physical-register commit indication consumed by rename and returning the superseded physical register to the free list. On a branch mispredict it squashes all entries younger than the mispredicted branch.

## Interface
- DEPTH, 16, number of entries; power of two, at least 4
- PREG_W, 6, physical register index width (64 physical registers)
- AREG_W, 5, architectural register index width (x0–x31)
- TAG_W, $clog2(DEPTH), entry tag width

Ports:
- clk_i  in  1  clock; single clock domain, all state updates on the rising edge
- rst_i  in  1  reset, synchronous, active-high
- alloc_valid_i  in  1  renamed instruction presented (rename output valid)
- alloc_ready_o  out  1  entry available; an allocation occurs when alloc_valid_i && alloc_ready_o
- alloc_rd_valid_i  in  1  instruction writes a destination register
- alloc_rd_arch_i  in  AREG_W  architectural destination register
- alloc_rd_phys_i  in  PREG_W  newly allocated physical destination register
- alloc_old_phys_i  in  PREG_W  previous mapping of rd, to be freed at retire
- alloc_tag_o  out  TAG_W  tag assigned to the allocation (current tail index)
- wb_valid_i  in  1  execution completion
- wb_tag_i  in  TAG_W  tag of the completing entry
- br_valid_i  in  1  branch resolved
- br_hit_i  in  1  1 = predicted correctly, 0 = mispredict
- br_tag_i  in  TAG_W  tag of the resolved branch
- p_commit_o  out  1+PREG_W  {valid, idx}: physical rd of the retired instruction, consumed by rename as p_commit
- free_valid_o  out  1  old physical register released
- free_idx_o  out  PREG_W  register released
- empty_o  out  1  no valid entries
- count_o  out  TAG_W+1  occupancy, 0..DEPTH

## Operation
- State: per-entry valid, done, rd_valid, rd_arch, rd_phys, old_phys; head_ptr and tail_ptr of TAG_W+1 bits each (MSB is the wrap bit).
- count = tail_ptr − head_ptr, computed modulo 2^(TAG_W+1).
- alloc_ready_o = (count != DEPTH). Ready is never asserted when the buffer is full, even if a retire happens in the same cycle.
- alloc_tag_o = tail_ptr[TAG_W-1:0].

Allocate:
- Writes the entry at tail with valid=1 and done=0.
- Sets rd_valid = alloc_rd_valid_i && (alloc_rd_arch_i != 0).
- Increments tail_ptr.

Writeback:
- Sets done on entry wb_tag_i only if that entry is valid.
- Writeback to an invalid or squashed entry is ignored.

Retire:
- Fires when the head entry is valid && done.
- Clears the entry's valid bit and increments head_ptr.
- Registered outputs next cycle:
  - p_commit_o = {1, rd_phys} if rd_valid, else {0, 0}.
  - free_valid_o = rd_valid, free_idx_o = old_phys.
- Rate: at most one retire per cycle.

Mispredict (br_valid_i && !br_hit_i, with entry br_tag_i valid):
- Clears valid on every entry strictly younger than br_tag_i.
- Sets tail_ptr to the pointer of br_tag_i + 1, keeping wrap-bit consistency with head.
- The branch entry itself stays and retires normally.
- Squashed entries do not produce free outputs; rename restores its own free list from its checkpoint.
- If br_hit_i=1, or entry br_tag_i is invalid, no action.

Simultaneous events:
- Mispredict and allocate in the same cycle: the allocation is dropped. The instruction is wrong-path; rename's flush covers it.
- Mispredict and retire in the same cycle: the retire proceeds. Head is never younger than the branch; if head == br_tag_i, the branch retires and the buffer becomes empty.
- Writeback to the head tag in the same cycle: done is set and the retire happens the following cycle (no bypass).
- Writeback to a tag squashed in the same cycle: ignored.

Reset:
- All entry valid and done bits 0, head_ptr = tail_ptr = 0.
- p_commit_o = 0, free_valid_o = 0, free_idx_o = 0.
- alloc_ready_o = 1, alloc_tag_o = 0, empty_o = 1, count_o = 0.
- Reset asserted mid-operation discards all entries with no commit or free outputs.

## Timing
- Allocate to retire-eligible: writeback at the earliest in the cycle after allocation. Retire fires the cycle after done is set. p_commit_o and free outputs are valid the cycle after that.
- Minimum path: allocation at edge N, writeback at edge N+1, retire at edge N+2, p_commit_o.valid high during cycle N+2 to N+3.
- p_commit_o, free_valid_o and free_idx_o are registered and hold for exactly one cycle per retire.
- count_o, empty_o, alloc_ready_o and alloc_tag_o derive combinationally from the pointers and reflect the state after the last edge.

## Test plan
- Reset: after reset, alloc_ready_o=1, empty_o=1, count_o=0, p_commit_o.valid=0.
- In-order retire with out-of-order completion:
  - Stimulus: allocate A(x5→p40, old p5), B(x6→p41, old p6); writeback B, then A.
  - Response: commit p40 then p41 on consecutive cycles; free p5 then p6.
- Full and wrap-around:
  - Stimulus: allocate 16 entries; alloc_ready_o drops at count 16. Retire 3, allocate 3 more.
  - Response: the new tags are 0, 1, 2 and count_o=16.
- x0 and no-rd cases:
  - Stimulus: entries with rd_arch=0, or alloc_rd_valid_i=0, retire.
  - Response: p_commit_o.valid=0 and free_valid_o=0 for those retires.
- Mispredict:
  - Stimulus: tags 0–5 allocated, branch at tag 2, mispredict.
  - Response: count_o=3 next cycle, the next alloc_tag_o=3, writeback to tag 4 ignored; tags 0–2 retire normally.
- Simultaneous events:
  - Stimulus: mispredict on tag == head while the head is done, with alloc_valid_i=1 in the same cycle.
  - Response: the branch retires, the allocation is dropped, and empty_o=1 afterwards.
